// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between a CPU port and a DMA port.
// Each access holds the memory strobes for MEM_LAT cycles and then pulses the owner's ack.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_adr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              c_ack_q, c_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_dma;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_dma   = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          // On a tie the port that did not win last time is served.
          grant_dma   = d_req && (!c_req || !last_q);
          owner_d     = grant_dma;
          last_d      = grant_dma;
          we_d        = grant_dma ? d_we : c_we;
          adr_d       = grant_dma ? d_adr : c_adr;
          wdata_d     = grant_dma ? d_wdata : c_wdata;
          cnt_d       = CNT_INIT;
          mem_read_d  = grant_dma ? !d_we : !c_we;
          mem_write_d = grant_dma ? d_we : c_we;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!we_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         c_rdata_d = mem_rdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          c_ack_d     = !owner_q;
          d_ack_d     = owner_q;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      c_ack_q     <= c_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign c_ack     = c_ack_q;
  assign d_ack     = d_ack_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 runs MEM_LAT=2, instance 1 runs MEM_LAT=1, both
// against a transaction-level model of grants, timing and memory contents.
module tb_mem_arbiter;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        c_req [2], c_we [2], d_req [2], d_we [2];
  logic [31:0] c_adr [2], c_wdata [2], d_adr [2], d_wdata [2];
  logic        c_ack [2], d_ack [2], mem_read [2], mem_write [2], busy [2], owner [2];
  logic [31:0] c_rdata [2], d_rdata [2], mem_adr [2], mem_wdata [2], mem_rdata [2];

  logic [31:0] mem_env [2][256];
  logic [31:0] mem_m [2][256];
  logic [31:0] rd_m [2][2];
  bit          last_m [2];
  time         ack_t [2];
  bit          served_dma;
  int          total = 0;
  int          bad = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2 - gi)) dut (
      .clk(clk), .rst(rst[gi]),
      .c_req(c_req[gi]), .c_we(c_we[gi]), .c_adr(c_adr[gi]), .c_wdata(c_wdata[gi]),
      .c_ack(c_ack[gi]), .c_rdata(c_rdata[gi]),
      .d_req(d_req[gi]), .d_we(d_we[gi]), .d_adr(d_adr[gi]), .d_wdata(d_wdata[gi]),
      .d_ack(d_ack[gi]), .d_rdata(d_rdata[gi]),
      .mem_read(mem_read[gi]), .mem_write(mem_write[gi]), .mem_adr(mem_adr[gi]),
      .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]),
      .busy(busy[gi]), .owner(owner[gi])
    );
    assign mem_rdata[gi] = mem_env[gi][mem_adr[gi][7:0]];
    always @(posedge clk) if (mem_write[gi]) mem_env[gi][mem_adr[gi][7:0]] <= mem_wdata[gi];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int k, input bit dma, input bit we, input logic [31:0] adr,
                          input logic [31:0] wd);
    if (dma) begin d_req[k] = 1; d_we[k] = we; d_adr[k] = adr; d_wdata[k] = wd; end
    else     begin c_req[k] = 1; c_we[k] = we; c_adr[k] = adr; c_wdata[k] = wd; end
  endtask

  // Called at a negedge while the DUT is idle; serves exactly one pending request.
  task automatic run_round(input int k);
    int          lat;
    bit          dma, we;
    logic [31:0] adr, wd;
    lat = 2 - k;
    if (c_req[k] && d_req[k]) dma = (last_m[k] == 1'b0);
    else                      dma = d_req[k];
    last_m[k] = dma;
    we  = dma ? d_we[k] : c_we[k];
    adr = dma ? d_adr[k] : c_adr[k];
    wd  = dma ? d_wdata[k] : c_wdata[k];
    @(posedge clk);
    for (int t = 1; t <= lat + 1; t++) begin
      @(negedge clk);
      chkb("strobe_excl", mem_read[k] & mem_write[k], 1'b0);
      if (t <= lat) begin
        chkb("mem_read", mem_read[k], !we);
        chkb("mem_write", mem_write[k], we);
        chk("mem_adr", mem_adr[k], adr);
        if (we) chk("mem_wdata", mem_wdata[k], wd);
        chkb("busy", busy[k], 1'b1);
        chkb("owner", owner[k], dma);
        chkb("c_ack_early", c_ack[k], 1'b0);
        chkb("d_ack_early", d_ack[k], 1'b0);
      end else begin
        if (we) mem_m[k][adr[7:0]] = wd;
        else    rd_m[k][dma] = mem_m[k][adr[7:0]];
        chkb("mem_read_off", mem_read[k], 1'b0);
        chkb("mem_write_off", mem_write[k], 1'b0);
        chkb("c_ack", c_ack[k], !dma);
        chkb("d_ack", d_ack[k], dma);
        chk("c_rdata", c_rdata[k], rd_m[k][0]);
        chk("d_rdata", d_rdata[k], rd_m[k][1]);
        ack_t[k]   = $time;
        served_dma = dma;
        if (dma) d_req[k] = 0;
        else     c_req[k] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chkb("busy_idle", busy[k], 1'b0);
    chkb("c_ack_off", c_ack[k], 1'b0);
    chkb("d_ack_off", d_ack[k], 1'b0);
    $display("txn inst=%0d owner=%0d we=%0d adr=%08h wdata=%08h c_rdata=%08h d_rdata=%08h",
             k, dma, we, adr, wd, c_rdata[k], d_rdata[k]);
  endtask

  task automatic random_rounds(input int k, input int n);
    bit cr, dr;
    for (int i = 0; i < n; i++) begin
      cr = !c_req[k] && ($urandom_range(0, 2) != 0);
      dr = !d_req[k] && ($urandom_range(0, 2) != 0);
      if (!c_req[k] && !d_req[k] && !cr && !dr) cr = 1;
      if (cr) set_port(k, 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      if (dr) set_port(k, 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      run_round(k);
    end
    while (c_req[k] || d_req[k]) run_round(k);
  endtask

  initial begin
    logic [31:0] v, sc, sd;
    time         t1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 0; c_req[k] = 0; d_req[k] = 0; c_we[k] = 0; d_we[k] = 0;
      c_adr[k] = 0; d_adr[k] = 0; c_wdata[k] = 0; d_wdata[k] = 0;
      last_m[k] = 1; rd_m[k][0] = 0; rd_m[k][1] = 0;
      for (int a = 0; a < 256; a++) begin
        v = (k == 0 && a == 8'h10) ? 32'hDEADBEEF : $urandom;
        mem_env[k][a] <= v;
        mem_m[k][a] = v;
      end
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chkb("rst_c_ack", c_ack[k], 1'b0);    chkb("rst_d_ack", d_ack[k], 1'b0);
      chkb("rst_mem_read", mem_read[k], 1'b0); chkb("rst_mem_write", mem_write[k], 1'b0);
      chkb("rst_busy", busy[k], 1'b0);      chkb("rst_owner", owner[k], 1'b0);
      chk("rst_mem_adr", mem_adr[k], 0);    chk("rst_mem_wdata", mem_wdata[k], 0);
      chk("rst_c_rdata", c_rdata[k], 0);    chk("rst_d_rdata", d_rdata[k], 0);
      rst[k] = 1;
    end

    // Simultaneous first request: CPU first, DMA one access later.
    set_port(0, 0, 0, 32'h10, 0);
    set_port(0, 1, 0, 32'h20, 0);
    run_round(0);
    chkb("first_owner_cpu", served_dma, 1'b0);
    chk("cpu_read_data", c_rdata[0], 32'hDEADBEEF);
    t1 = ack_t[0];
    run_round(0);
    chkb("second_owner_dma", served_dma, 1'b1);
    chk("dma_ack_gap", 32'(ack_t[0] - t1), 40);

    // Plain CPU read, then DMA write leaving both read registers alone.
    set_port(0, 0, 0, 32'h10, 0);
    run_round(0);
    chk("cpu_read_again", c_rdata[0], 32'hDEADBEEF);
    sc = c_rdata[0]; sd = d_rdata[0];
    set_port(0, 1, 1, 32'h40, 32'h12345678);
    run_round(0);
    chk("write_keeps_c_rdata", c_rdata[0], sc);
    chk("write_keeps_d_rdata", d_rdata[0], sd);
    chk("mem_written", mem_env[0][8'h40], 32'h12345678);

    // Both requests held: strict alternation, one access per 4 cycles.
    for (int i = 0; i < 6; i++) begin
      if (!c_req[0]) set_port(0, 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      if (!d_req[0]) set_port(0, 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      t1 = ack_t[0];
      run_round(0);
      chkb("alternate_owner", served_dma, 1'(i % 2));
      if (i > 0) chk("held_period", 32'(ack_t[0] - t1), 40);
    end
    run_round(0);

    // Asynchronous reset in the middle of a read.
    set_port(0, 0, 0, 32'h10, 0);
    @(posedge clk);
    @(negedge clk);
    chkb("pre_rst_mem_read", mem_read[0], 1'b1);
    #2 rst[0] = 0;
    #1;
    chkb("async_mem_read", mem_read[0], 1'b0);
    chkb("async_busy", busy[0], 1'b0);
    chkb("async_c_ack", c_ack[0], 1'b0);
    chk("async_c_rdata", c_rdata[0], 0);
    c_req[0] = 0;
    last_m[0] = 1; rd_m[0][0] = 0; rd_m[0][1] = 0;
    @(negedge clk);
    rst[0] = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chkb("no_ack_after_rst", c_ack[0], 1'b0);
      chkb("idle_after_rst", busy[0], 1'b0);
    end
    set_port(0, 0, 0, 32'h10, 0);
    set_port(0, 1, 0, 32'h40, 0);
    run_round(0);
    chkb("post_rst_cpu_first", served_dma, 1'b0);
    run_round(0);
    chk("post_rst_dma_read", d_rdata[0], 32'h12345678);

    random_rounds(0, 30);

    // MEM_LAT=1: back-to-back CPU reads, one ack every 3 cycles.
    for (int i = 0; i < 5; i++) begin
      set_port(1, 0, 0, 32'($urandom_range(0, 255)), 0);
      t1 = ack_t[1];
      run_round(1);
      if (i > 0) chk("lat1_period", 32'(ack_t[1] - t1), 30);
    end
    random_rounds(1, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single unified instruction/data memory of the multi-cycle MIPS core between the CPU and a DMA/loader requester.
- Each requester uses a req/ack handshake.
- The arbiter serialises accesses with round-robin fairness, drives the memory strobes for a fixed access latency, and returns read data to the owner.
- Sits between the core (adr, memRead, memWrite, outRegB, memOut) and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles the memory strobes are held before read data is sampled; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- c_req  in  1  CPU request; held high until c_ack.
- c_we  in  1  CPU write enable (1 = write, 0 = read).
- c_adr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU write data.
- c_ack  out  1  CPU completion pulse, one cycle.
- c_rdata  out  DATA_W  CPU read data; valid while c_ack is high, held until the next CPU read completes.
- d_req, d_we, d_adr, d_wdata  in  1/1/ADDR_W/DATA_W  DMA port, same rules as the CPU port.
- d_ack  out  1  DMA completion pulse.
- d_rdata  out  DATA_W  DMA read data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_adr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when the state is not IDLE.
- owner  out  1  current owner (0 = CPU, 1 = DMA); meaningful only while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - All acks, strobes, mem_adr, mem_wdata, c_rdata, d_rdata, owner and cnt = 0.
  - last_grant = 1 (DMA), so the CPU wins the first tie.
  - An in-flight transaction is discarded with no ack.
- All outputs are registered.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both reqs: grant the port opposite last_grant.
  - On grant:
    - Latch the owner's adr, we and wdata.
    - Set owner; last_grant = owner.
    - cnt = MEM_LAT-1.
    - Go to ACCESS.
- ACCESS:
  - mem_adr and mem_wdata are driven from the latched values.
  - mem_read = ~we_l, mem_write = we_l.
  - Only the latched values drive the memory; requester inputs are ignored until ack.
  - cnt>0: decrement cnt.
  - cnt==0:
    - On a read, capture mem_rdata into the owner's rdata register.
    - Deassert both strobes and go to RESP.
- RESP:
  - Owner's ack = 1 for exactly this cycle; the other ack stays 0.
  - Go to IDLE.
- Timing: with req sampled at edge E, strobes are high for cycles E+1..E+MEM_LAT and ack is high in cycle E+MEM_LAT+1.
  - Throughput is one access per MEM_LAT+2 cycles.
  - MEM_LAT=1 gives exactly one strobe cycle.
- Requester protocol:
  - Drop req, or present the next request, at the edge that ends the ack cycle.
  - A req still high in IDLE is treated as a new request, so back-to-back requests are allowed.
- Fairness: with both reqs continuously high, grants alternate CPU, DMA, CPU, …. No starvation beyond one access.
- A write leaves the rdata registers unchanged.
- A non-owner's rdata is never modified.
- A req that changes while not owner is honoured only from its value sampled in IDLE.
- mem_read and mem_write are never high simultaneously.
- Strobes are never high outside ACCESS.

Test Plan:
- CPU read, MEM_LAT=2:
  - Stimulus: c_req=1, c_adr=0x10, with mem returning 0xDEADBEEF.
  - Required: mem_read high for 2 cycles with mem_adr=0x10; c_ack high 3 cycles after the req edge; c_rdata=0xDEADBEEF; d_ack stays 0.
- DMA write:
  - Stimulus: d_we=1, d_adr=0x40, d_wdata=0x12345678.
  - Required: mem_write high 2 cycles with correct adr/wdata; d_ack pulse; d_rdata and c_rdata unchanged.
- Simultaneous first request after reset:
  - Required: CPU granted first (owner=0); DMA completes next, with d_ack 4 cycles after c_ack.
- Both reqs held for 6 accesses:
  - Required: owners alternate 0,1,0,1,0,1; each access takes 4 cycles; strobes never overlap.
- Reset mid-ACCESS:
  - Stimulus: assert rst=0 asynchronously during a read.
  - Required: strobes, acks and busy drop immediately without waiting for a clock; no ack after release; the next request is served normally.
- MEM_LAT=1, back-to-back CPU reads:
  - Required: single-cycle mem_read per access; c_ack every 3 cycles with correct data per address.
